// File: rtl/mig_pkg.sv
// Shared widths and types for the MIG command-port arbiter.
// The localparams are the default configuration; the modules default their parameters to them.
package mig_pkg;

  localparam int MIG_N_REQ  = 2;
  localparam int MIG_MAX_RD = 4;
  localparam int MIG_DATA_W = 128;
  localparam int MIG_ADDR_W = 28;
  localparam int MIG_STRB_W = MIG_DATA_W / 8;

  typedef logic [MIG_DATA_W-1:0]         mig_data_t;
  typedef logic [MIG_ADDR_W-1:0]         mig_addr_t;
  typedef logic [MIG_STRB_W-1:0]         strb_t;
  typedef logic [$clog2(MIG_N_REQ)-1:0]  req_idx_t;

endpackage

// File: rtl/mig_arbiter_if.sv
// MIG user command/data port.
// The master side (the arbiter) drives command and write data.
// The slave side (the MIG) drives the readies and the read data.
interface mig_arbiter_if
  import mig_pkg::*;
#(
  parameter int DATA_W = MIG_DATA_W,
  parameter int ADDR_W = MIG_ADDR_W,
  parameter int STRB_W = DATA_W / 8
);

  logic              en;
  logic              w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] strb;
  logic              ready;
  logic              w_ready;
  logic              valid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output en, w_en, addr, wdata, strb,
    input  ready, w_ready, valid, rdata
  );

  modport slave (
    input  en, w_en, addr, wdata, strb,
    output ready, w_ready, valid, rdata
  );

endinterface

// File: rtl/mig_arbiter_rr.sv
// Pure combinational round-robin picker.
// It returns the first eligible index at or after ptr, wrapping from N-1 to 0.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         eligible_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 any_grant_o
);

  localparam int IW = $clog2(N);

  int idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_grant_o && eligible_i[idx]) begin
        any_grant_o      = 1'b1;
        grant_o[idx]     = 1'b1;
        grant_idx_o      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mig_arbiter.sv
// Round-robin sharing of the MIG user command port, one command per cycle.
// An in-order tag queue routes each returned read beat back to the requester that issued the read.
module mig_arbiter
  import mig_pkg::*;
#(
  parameter int N_REQ  = MIG_N_REQ,
  parameter int MAX_RD = MIG_MAX_RD,
  parameter int DATA_W = MIG_DATA_W,
  parameter int ADDR_W = MIG_ADDR_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_reset_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           req_write_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]    req_data_i,
  input  logic [N_REQ*STRB_W-1:0]    req_strb_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(MAX_RD):0]    rd_outstanding_o,
  output logic                       err_o,
  mig_arbiter_if.master              mig
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(MAX_RD);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] tags_q [MAX_RD];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gidx;
  logic             any_grant;
  logic             tag_full;
  logic             push, pop;
  logic [IDX_W-1:0] head;

  assign tag_full = (cnt_q == CNT_W'(MAX_RD));

  // Gated by reset so the combinational command path goes quiet the instant reset asserts.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = sys_reset_ni && req_i[i] && mig.ready &&
                    (req_write_i[i] ? mig.w_ready : !tag_full);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .eligible_i  (eligible),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .any_grant_o (any_grant)
  );

  always_comb begin
    ack_o     = grant;
    mig.en    = any_grant;
    mig.w_en  = 1'b0;
    mig.addr  = '0;
    mig.wdata = '0;
    mig.strb  = '0;
    if (any_grant) begin
      mig.w_en  = req_write_i[gidx];
      mig.addr  = req_addr_i[gidx*ADDR_W +: ADDR_W];
      mig.wdata = req_data_i[gidx*DATA_W +: DATA_W];
      mig.strb  = req_strb_i[gidx*STRB_W +: STRB_W];
    end
  end

  assign push = any_grant && !req_write_i[gidx];
  assign pop  = mig.valid && (cnt_q != '0);
  assign head = tags_q[rd_ptr_q];

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (pop) begin
      rdata_o = mig.rdata;
      for (int i = 0; i < N_REQ; i++) begin
        rvalid_o[i] = (head == IDX_W'(i));
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
    end
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_RD; i++) tags_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        tags_q[wr_ptr_q] <= gidx;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (mig.valid && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  assign rd_outstanding_o = cnt_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_mig_arbiter.sv
// Directed bench for mig_arbiter: round-robin order, read routing, tag-full stall,
// write-ready gating, command-ready hold and asynchronous reset.
module tb_mig_arbiter;
  import mig_pkg::*;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    ack, rvalid;
  logic [DW-1:0]   rdata;
  logic [2:0]      rd_out;
  logic            err;

  int checks = 0;
  int errors = 0;

  mig_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mig ();

  mig_arbiter #(.N_REQ(N), .MAX_RD(4), .DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk_i        (clk),
    .sys_reset_ni     (rst_n),
    .req_i            (req),
    .req_write_i      (req_write),
    .req_addr_i       (req_addr),
    .req_data_i       (req_data),
    .req_strb_i       (req_strb),
    .ack_o            (ack),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .rd_outstanding_o (rd_out),
    .err_o            (err),
    .mig              (mig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input mig_addr_t a,
                         input mig_data_t d, input strb_t s);
    req_write[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
  endtask

  task automatic idle_inputs();
    req         = '0;
    req_write   = '0;
    req_addr    = '0;
    req_data    = '0;
    req_strb    = '0;
    mig.ready   = 1'b1;
    mig.w_ready = 1'b1;
    mig.valid   = 1'b0;
    mig.rdata   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_req(0, 1'b1, 28'h10, {4{32'h1}}, '1);
    set_req(1, 1'b1, 28'h20, {4{32'h2}}, '1);
    req   = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mig.en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", mig.en); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (mig.addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mig.addr); end
    checks++; if (rd_out !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", rd_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
    rst_n = 1'b1;
    req   = '0;
    #1;
  endtask

  task automatic test_alternate_writes();
    logic [N-1:0] exp_ack;
    mig_addr_t    exp_addr;
    do_reset();
    set_req(0, 1'b1, 28'h0AA0, {4{32'hA0A0A0A0}}, 16'h00FF);
    set_req(1, 1'b1, 28'h0BB0, {4{32'hB0B0B0B0}}, 16'hFF00);
    req = 2'b11;
    #1;
    for (int c = 0; c < 5; c++) begin
      exp_ack  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (c % 2 == 0) ? 28'h0AA0 : 28'h0BB0;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL alt_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
      checks++; if (mig.w_en !== 1'b1) begin errors++; $display("FAIL alt_wen c=%0d got=%b exp=1", c, mig.w_en); end
      checks++; if (mig.addr !== exp_addr) begin errors++; $display("FAIL alt_addr c=%0d got=%h exp=%h", c, mig.addr, exp_addr); end
      step();
    end
    checks++; if (rd_out !== 3'd0) begin errors++; $display("FAIL alt_no_tags got=%0d exp=0", rd_out); end
    req = '0;
  endtask

  task automatic test_read_routing();
    do_reset();
    set_req(0, 1'b0, 28'h100, '0, '0);
    set_req(1, 1'b0, 28'h200, '0, '0);
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b01 || mig.addr !== 28'h100 || mig.w_en !== 1'b0)
      begin errors++; $display("FAIL rd0_cmd got ack=%b addr=%h wen=%b exp ack=01 addr=100 wen=0", ack, mig.addr, mig.w_en); end
    step();
    req = 2'b10;
    #1;
    checks++; if (ack !== 2'b10 || mig.addr !== 28'h200)
      begin errors++; $display("FAIL rd1_cmd got ack=%b addr=%h exp ack=10 addr=200", ack, mig.addr); end
    step();
    req = '0;
    step();
    step();
    checks++; if (rd_out !== 3'd2) begin errors++; $display("FAIL rd_cnt2 got=%0d exp=2", rd_out); end
    mig.valid = 1'b1;
    mig.rdata = 128'hAAAA;
    #1;
    checks++; if (rvalid !== 2'b01 || rdata !== 128'hAAAA)
      begin errors++; $display("FAIL rd_ret0 got rvalid=%b rdata=%h exp 01/AAAA", rvalid, rdata); end
    step();
    mig.rdata = 128'hBBBB;
    #1;
    checks++; if (rvalid !== 2'b10 || rdata !== 128'hBBBB)
      begin errors++; $display("FAIL rd_ret1 got rvalid=%b rdata=%h exp 10/BBBB", rvalid, rdata); end
    step();
    mig.valid = 1'b0;
    mig.rdata = 128'hCCCC;
    #1;
    checks++; if (rvalid !== 2'b00 || rdata !== '0 || rd_out !== 3'd0)
      begin errors++; $display("FAIL rd_idle got rvalid=%b rdata=%h cnt=%0d exp 00/0/0", rvalid, rdata, rd_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", err); end
    mig.rdata = '0;
  endtask

  task automatic test_tag_full();
    int acks = 0;
    do_reset();
    set_req(0, 1'b0, 28'h300, '0, '0);
    req = 2'b01;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (ack == 2'b01) acks++;
      step();
    end
    checks++; if (acks != 4) begin errors++; $display("FAIL full_acks got=%0d exp=4", acks); end
    checks++; if (rd_out !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", rd_out); end
    checks++; if (mig.en !== 1'b0) begin errors++; $display("FAIL full_en got=%b exp=0", mig.en); end
    mig.valid = 1'b1;
    mig.rdata = 128'h1234;
    #1;
    checks++; if (ack !== 2'b00 || rvalid !== 2'b01)
      begin errors++; $display("FAIL full_pop_cycle got ack=%b rvalid=%b exp 00/01", ack, rvalid); end
    step();
    mig.valid = 1'b0;
    #1;
    checks++; if (rd_out !== 3'd3 || ack !== 2'b01)
      begin errors++; $display("FAIL full_regrant got cnt=%0d ack=%b exp 3/01", rd_out, ack); end
    step();
    checks++; if (rd_out !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", rd_out); end
    req = '0;
  endtask

  task automatic test_w_ready_gate();
    do_reset();
    set_req(0, 1'b1, 28'h400, {4{32'hDEADBEEF}}, 16'h0F0F);
    set_req(1, 1'b0, 28'h500, '0, '0);
    mig.w_ready = 1'b0;
    req = 2'b11;
    #1;
    checks++; if (ack !== 2'b10 || mig.w_en !== 1'b0 || mig.addr !== 28'h500)
      begin errors++; $display("FAIL wr_gate_rd got ack=%b wen=%b addr=%h exp 10/0/500", ack, mig.w_en, mig.addr); end
    step();
    req = 2'b01;
    #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_gate_hold got=%b exp=00", ack); end
    step();
    mig.w_ready = 1'b1;
    #1;
    checks++; if (ack !== 2'b01 || mig.w_en !== 1'b1 || mig.wdata !== {4{32'hDEADBEEF}} || mig.strb !== 16'h0F0F)
      begin errors++; $display("FAIL wr_gate_go got ack=%b wen=%b data=%h strb=%h", ack, mig.w_en, mig.wdata, mig.strb); end
    step();
    req = '0;
  endtask

  task automatic test_ready_hold();
    do_reset();
    set_req(0, 1'b1, 28'h600, '0, '0);
    set_req(1, 1'b1, 28'h700, '0, '0);
    req = 2'b01;
    step();
    req       = 2'b11;
    mig.ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack !== 2'b00 || mig.en !== 1'b0 || mig.addr !== '0)
        begin errors++; $display("FAIL rdy_hold c=%0d got ack=%b en=%b addr=%h exp 00/0/0", c, ack, mig.en, mig.addr); end
      step();
    end
    mig.ready = 1'b1;
    #1;
    checks++; if (ack !== 2'b10 || mig.addr !== 28'h700)
      begin errors++; $display("FAIL rdy_release got ack=%b addr=%h exp 10/700", ack, mig.addr); end
    step();
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 1'b0, 28'h800, '0, '0);
    req = 2'b01;
    step();
    step();
    #1;
    checks++; if (rd_out !== 3'd2) begin errors++; $display("FAIL ar_cnt_before got=%0d exp=2", rd_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mig.en !== 1'b0 || ack !== 2'b00 || rd_out !== 3'd0 || rvalid !== 2'b00)
      begin errors++; $display("FAIL ar_immediate got en=%b ack=%b cnt=%0d rvalid=%b exp 0/00/0/00", mig.en, ack, rd_out, rvalid); end
    req = '0;
    step();
    rst_n = 1'b1;
    step();
    mig.valid = 1'b1;
    mig.rdata = 128'h5555;
    #1;
    checks++; if (rvalid !== 2'b00 || rdata !== '0)
      begin errors++; $display("FAIL ar_stray got rvalid=%b rdata=%h exp 00/0", rvalid, rdata); end
    step();
    mig.valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_err got=%b exp=1", err); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_err_sticky got=%b exp=1", err); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alternate_writes();
    test_read_routing();
    test_tag_full();
    test_w_ready_gate();
    test_ready_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
